// File: rtl/dec_gray_tracker.sv
// Gray-code position tracker: decodes Gray samples to binary, classifies each
// step against the previous sample and keeps a saturating error count.
module dec_gray_tracker #(
  parameter int W  = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_gray,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bin,
  output logic          out_step,
  output logic          out_dir,
  output logic          out_err,
  output logic          out_first,
  output logic [CW-1:0] err_count
);

  logic [W-1:0] dec_bin;
  logic [W-1:0] a_bin;
  logic         a_v;
  logic [W-1:0] prev_bin;
  logic         first_pending;
  logic [W-1:0] delta;
  logic         in_fire;
  logic         b_load;
  logic         step_n;
  logic         dir_n;
  logic         err_n;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    dec_bin = '0;
    for (int i = 0; i < W; i++) begin
      dec_bin[i] = ^(in_gray >> i);
    end
  end

  assign in_ready = !clear && (!a_v || !out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign b_load   = a_v && (!out_valid || out_ready);
  assign delta    = a_bin - prev_bin;

  always_comb begin
    step_n = 1'b0;
    dir_n  = 1'b0;
    err_n  = 1'b0;
    if (!first_pending) begin
      if (delta == W'(1)) begin
        step_n = 1'b1;
        dir_n  = 1'b1;
      end else if (delta == {W{1'b1}}) begin
        step_n = 1'b1;
      end else if (delta != '0) begin
        err_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_v   <= 1'b0;
      a_bin <= '0;
    end else if (clear) begin
      a_v <= 1'b0;
    end else if (in_fire) begin
      a_v   <= 1'b1;
      a_bin <= dec_bin;
    end else if (b_load) begin
      a_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_bin       <= '0;
      out_step      <= 1'b0;
      out_dir       <= 1'b0;
      out_err       <= 1'b0;
      out_first     <= 1'b0;
      prev_bin      <= '0;
      first_pending <= 1'b1;
      err_count     <= '0;
    end else if (clear) begin
      out_valid     <= 1'b0;
      first_pending <= 1'b1;
      err_count     <= '0;
    end else if (b_load) begin
      out_valid     <= 1'b1;
      out_bin       <= a_bin;
      out_step      <= step_n;
      out_dir       <= dir_n;
      out_err       <= err_n;
      out_first     <= first_pending;
      // prev follows every loaded sample so an error resynchronises tracking
      prev_bin      <= a_bin;
      first_pending <= 1'b0;
      if (err_n && (err_count != {CW{1'b1}})) begin
        err_count <= err_count + CW'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_gray_tracker.sv
// Bench for dec_gray_tracker: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of accepted samples.
module tb_dec_gray_tracker;
  localparam int W    = 10;
  localparam int CW   = 8;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_gray = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_bin;
  logic          out_step;
  logic          out_dir;
  logic          out_err;
  logic          out_first;
  logic [CW-1:0] err_count;

  dec_gray_tracker #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_step(out_step), .out_dir(out_dir), .out_err(out_err),
    .out_first(out_first), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin; bit step; bit dir; bit err; bit first; int cum; int e;
  } ent_t;

  ent_t q[$];
  ent_t lg[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   drv_bin = 0;
  int   m_prev = 0;
  bit   m_first = 1'b1;
  int   m_cum = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int enc(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  function automatic bit visible();
    return (q.size() > 0) && (q[0].e + 2 <= cyc);
  endfunction

  // Model: pipeline content is the ordered list of accepted samples.
  always @(posedge clk) begin
    if (rst || clear) begin
      q.delete();
      m_first = 1'b1;
      m_cum   = 0;
    end else begin
      bit   rdy;
      ent_t n;
      int   d;
      rdy = (q.size() < 2) || out_ready;
      if (visible() && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        n = '{bin: drv_bin, step: 0, dir: 0, err: 0, first: 0, cum: 0, e: cyc};
        d = (drv_bin - m_prev) & MASK;
        if (m_first) n.first = 1'b1;
        else if (d == 1) begin n.step = 1'b1; n.dir = 1'b1; end
        else if (d == MASK) n.step = 1'b1;
        else if (d != 0) n.err = 1'b1;
        if (n.err && m_cum < (1 << CW) - 1) m_cum++;
        n.cum   = m_cum;
        m_prev  = drv_bin;
        m_first = 1'b0;
        q.push_back(n);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", int'(in_ready), int'(!clear && ((q.size() < 2) || out_ready)));
      chk("out_valid", int'(out_valid), int'(visible()));
      if (visible()) begin
        chk("out_bin", int'(out_bin), q[0].bin);
        chk("flags", int'({out_step, out_dir, out_err, out_first}),
            int'({q[0].step, q[0].dir, q[0].err, q[0].first}));
        chk("err_count", int'(err_count), q[0].cum);
      end
      if (out_valid && out_ready && !clear)
        lg.push_back('{bin: int'(out_bin), step: out_step, dir: out_dir, err: out_err,
                       first: out_first, cum: int'(err_count), e: cyc});
    end
  end

  task automatic drive(input bit v, input int b, input bit ordy, input bit clr);
    @(posedge clk); #1;
    in_valid  = v;
    drv_bin   = b & MASK;
    in_gray   = W'(enc(b));
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0);
  endtask

  task automatic chk_log(input int idx, input string nm, input int bin,
                         input bit step, input bit dir, input bit err, input bit first);
    if (idx >= lg.size()) begin
      chk({nm, "_present"}, lg.size(), idx + 1);
    end else begin
      chk(nm, (lg[idx].bin << 4) | {lg[idx].step, lg[idx].dir, lg[idx].err, lg[idx].first},
          (bin << 4) | {step, dir, err, first});
    end
  endtask

  initial begin
    int cur;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // up stream
    lg.delete();
    for (int i = 0; i < 4; i++) drive(1, i, 1, 0);
    idle(3);
    chk_log(0, "up0", 0, 0, 0, 0, 1);
    chk_log(1, "up1", 1, 1, 1, 0, 0);
    chk_log(2, "up2", 2, 1, 1, 0, 0);
    chk_log(3, "up3", 3, 1, 1, 0, 0);

    // down stream with wrap
    drive(0, 0, 1, 1);
    lg.delete();
    drive(1, 1, 1, 0); drive(1, 0, 1, 0); drive(1, 1023, 1, 0); drive(1, 1022, 1, 0);
    idle(3);
    chk_log(0, "dn0", 1, 0, 0, 0, 1);
    chk_log(1, "dn1", 0, 1, 0, 0, 0);
    chk_log(2, "dn2", 1023, 1, 0, 0, 0);
    chk_log(3, "dn3", 1022, 1, 0, 0, 0);

    // illegal jump and resync
    drive(0, 0, 1, 1);
    lg.delete();
    drive(1, 5, 1, 0); drive(1, 9, 1, 0); drive(1, 10, 1, 0);
    idle(3);
    chk_log(1, "jump", 9, 0, 0, 1, 0);
    chk_log(2, "resync", 10, 1, 1, 0, 0);
    if (lg.size() > 1) chk("jump_cnt", lg[1].cum, 1);

    // clear while both stages full (one more error first)
    drive(1, 40, 0, 0); drive(1, 41, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    @(negedge clk);
    chk("clr_out_valid", int'(out_valid), 0);
    chk("clr_err_count", int'(err_count), 0);
    lg.delete();
    drive(1, 100, 1, 0);
    idle(3);
    chk_log(0, "clr_first", 100, 0, 0, 0, 1);

    // backpressure: three offered, two absorbed
    drive(0, 0, 1, 1);
    lg.delete();
    drive(1, 20, 0, 0); drive(1, 21, 0, 0); drive(1, 22, 0, 0);
    @(negedge clk);
    chk("bp_in_ready", int'(in_ready), 0);
    idle(4);
    chk("bp_count", lg.size(), 2);
    chk_log(0, "bp0", 20, 0, 0, 0, 1);
    chk_log(1, "bp1", 21, 1, 1, 0, 0);

    // saturation: 300 illegal transitions
    drive(0, 0, 1, 1);
    for (int i = 0; i <= 300; i++) drive(1, (i % 2) * 512, 1, 0);
    idle(3);
    @(negedge clk);
    chk("sat_err_count", int'(err_count), 255);

    // random traffic
    drive(0, 0, 1, 1);
    cur = $urandom_range(0, MASK);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 7);
      if (r <= 2) cur = (cur + 1) & MASK;
      else if (r <= 4) cur = (cur - 1) & MASK;
      else if (r >= 6) cur = $urandom_range(0, MASK);
      drive($urandom_range(0, 3) != 0, cur, $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
